// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR addresses, op encoding and mstatus field positions
// Contents: machine-mode CSR address map, csr_op_e, mstatus bit indices, misa value.
package csr_pkg;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {
        CSR_NOP = 2'b00,
        CSR_RW  = 2'b01,
        CSR_RS  = 2'b10,
        CSR_RC  = 2'b11
    } csr_op_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [31:0] MISA_VAL = 32'h4000_0100;

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit counter with independently writable 32-bit halves
// Ports: clk, rst (sync, active-high), inc (count enable), wr_lo/wr_hi (half write
// strobes, never both), wdata (half write data), count (current 64-bit value).
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    // A half write replaces that half only: the increment (and its carry) is
    // skipped for the whole counter in that cycle.
    always_comb begin
        count_d = count_q;
        if (wr_lo) begin
            count_d[31:0] = wdata;
        end else if (wr_hi) begin
            count_d[63:32] = wdata;
        end else if (inc) begin
            count_d = count_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/csr_trap_unit.sv
// rtl/csr_trap_unit.sv - machine-mode CSR file with trap entry, mret and perf counters
// Ports: clk/rst (sync, active-high); csr_valid/csr_op/csr_addr/csr_wdata CSR access
// in, csr_rdata (old value) and csr_illegal out, both combinational; trap_valid/
// trap_cause/trap_pc trap entry; mret_valid return; instret_inc retire pulse;
// redirect_pc new PC for trap/mret; mstatus_o/mepc_o current register values.
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter bit              HAS_COUNTERS = 1'b1,
    parameter logic [XLEN-1:0] MSTATUS_RST  = 32'h0000_1800,
    parameter logic [XLEN-1:0] MTVEC_RST    = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret_valid,
    input  logic            instret_inc,
    output logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] mstatus_o,
    output logic [XLEN-1:0] mepc_o
);

    csr_op_e         op;
    logic [XLEN-1:0] mstatus_q, mstatus_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [63:0]     mcycle, minstret;
    logic            mapped, read_only, is_write, csr_we;
    logic [XLEN-1:0] old_val, new_val;
    logic            cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;
    logic            unused_pc_bits;

    assign op = csr_op_e'(csr_op);

    always_comb begin
        mapped  = 1'b1;
        old_val = '0;
        case (csr_addr)
            ADDR_MSTATUS:   old_val = mstatus_q;
            ADDR_MISA:      old_val = MISA_VAL;
            ADDR_MTVEC:     old_val = mtvec_q;
            ADDR_MSCRATCH:  old_val = mscratch_q;
            ADDR_MEPC:      old_val = mepc_q;
            ADDR_MCAUSE:    old_val = mcause_q;
            ADDR_MCYCLE:    begin mapped = HAS_COUNTERS; old_val = mcycle[31:0];    end
            ADDR_MCYCLEH:   begin mapped = HAS_COUNTERS; old_val = mcycle[63:32];   end
            ADDR_MINSTRET:  begin mapped = HAS_COUNTERS; old_val = minstret[31:0];  end
            ADDR_MINSTRETH: begin mapped = HAS_COUNTERS; old_val = minstret[63:32]; end
            ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID, ADDR_MHARTID: old_val = '0;
            default:        mapped = 1'b0;
        endcase
    end

    // RS/RC with a zero mask are pure reads, so they are legal even on RO CSRs.
    assign read_only   = (csr_addr[11:10] == 2'b11) || (csr_addr == ADDR_MISA);
    assign is_write    = (op == CSR_RW) || (((op == CSR_RS) || (op == CSR_RC)) && (csr_wdata != '0));
    assign csr_illegal = csr_valid && (!mapped || (is_write && read_only));
    assign csr_we      = csr_valid && is_write && !csr_illegal && !trap_valid && !mret_valid;
    assign csr_rdata   = old_val;

    always_comb begin
        case (op)
            CSR_RW:  new_val = csr_wdata;
            CSR_RS:  new_val = old_val | csr_wdata;
            CSR_RC:  new_val = old_val & ~csr_wdata;
            default: new_val = old_val;
        endcase
    end

    // Trap beats mret beats the CSR write; losers have no effect at all.
    always_comb begin
        mstatus_d  = mstatus_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (trap_valid) begin
            mepc_d                                   = {trap_pc[XLEN-1:2], 2'b00};
            mcause_d                                 = trap_cause;
            mstatus_d[MSTATUS_MPIE]                  = mstatus_q[MSTATUS_MIE];
            mstatus_d[MSTATUS_MIE]                   = 1'b0;
            mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        end else if (mret_valid) begin
            mstatus_d[MSTATUS_MIE]                   = mstatus_q[MSTATUS_MPIE];
            mstatus_d[MSTATUS_MPIE]                  = 1'b1;
            mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        end else if (csr_we) begin
            case (csr_addr)
                ADDR_MSTATUS:  mstatus_d  = new_val;
                ADDR_MTVEC:    mtvec_d    = {new_val[XLEN-1:2], 2'b00};
                ADDR_MSCRATCH: mscratch_d = new_val;
                ADDR_MEPC:     mepc_d     = {new_val[XLEN-1:2], 2'b00};
                ADDR_MCAUSE:   mcause_d   = new_val;
                default:       ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_q  <= MSTATUS_RST;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mstatus_q  <= mstatus_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    assign cyc_wr_lo = csr_we && (csr_addr == ADDR_MCYCLE);
    assign cyc_wr_hi = csr_we && (csr_addr == ADDR_MCYCLEH);
    assign ins_wr_lo = csr_we && (csr_addr == ADDR_MINSTRET);
    assign ins_wr_hi = csr_we && (csr_addr == ADDR_MINSTRETH);

    generate
        if (HAS_COUNTERS) begin : g_counters
            csr_counter64 u_mcycle (
                .clk   (clk),
                .rst   (rst),
                .inc   (1'b1),
                .wr_lo (cyc_wr_lo),
                .wr_hi (cyc_wr_hi),
                .wdata (new_val),
                .count (mcycle)
            );
            csr_counter64 u_minstret (
                .clk   (clk),
                .rst   (rst),
                .inc   (instret_inc),
                .wr_lo (ins_wr_lo),
                .wr_hi (ins_wr_hi),
                .wdata (new_val),
                .count (minstret)
            );
        end else begin : g_no_counters
            logic unused_counter_inputs;
            assign unused_counter_inputs = ^{cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi, instret_inc};
            assign mcycle   = '0;
            assign minstret = '0;
        end
    endgenerate

    // The low PC bits are discarded by the mepc alignment.
    assign unused_pc_bits = ^trap_pc[1:0];

    assign redirect_pc = trap_valid ? mtvec_q : (mret_valid ? mepc_q : '0);
    assign mstatus_o   = mstatus_q;
    assign mepc_o      = mepc_q;

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
Parametrised machine-mode CSR file with trap/return sequencing and 64-bit performance counters. Successor to the four-register CSR block: adds CSRRW/CSRRS/CSRRC semantics, hardware trap entry and mret, counter CSRs and illegal-access flagging. Sits beside the execute stage. Decode supplies the CSR op; the exception/commit logic supplies trap, mret and retire pulses. Outputs feed the PC-select mux.

Parameters:
XLEN, 32, data width of all CSRs (32 only; counters split into low/high halves)
HAS_COUNTERS, 1, 1 = implement mcycle/minstret (+h halves); 0 = those addresses are illegal
MSTATUS_RST, 32'h0000_1800, mstatus reset value (MPP=11)
MTVEC_RST, 32'h0, mtvec reset value

Ports:
clk  in  1  clock
rst  in  1  reset rst, synchronous, active-high; clock clk
csr_valid  in  1  CSR instruction present this cycle
csr_op  in  2  01=RW, 10=RS (set), 11=RC (clear), 00=no-op
csr_addr  in  12  CSR address
csr_wdata  in  XLEN  rs1 value or zero-extended uimm
csr_rdata  out  XLEN  old CSR value, combinational
csr_illegal  out  1  combinational: access is illegal
trap_valid  in  1  take exception this cycle
trap_cause  in  XLEN  mcause value to record
trap_pc  in  XLEN  faulting PC
mret_valid  in  1  execute mret this cycle
instret_inc  in  1  one instruction retired this cycle
redirect_pc  out  XLEN  mtvec (when trapping) or mepc (mret), combinational
mstatus_o  out  XLEN  current mstatus
mepc_o  out  XLEN  current mepc

Behaviour:
- Reset: mstatus=MSTATUS_RST, mtvec=MTVEC_RST, mepc=0, mcause=0, mscratch=0, counters=0. csr_rdata/csr_illegal follow reset state; no writes are pending.
- Map: 0x300 mstatus, 0x301 misa (RO constant 32'h4000_0100), 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0xB00/0xB80 mcycle/h, 0xB02/0xB82 minstret/h, 0xF11-0xF14 (RO, read 0).
- Read: csr_rdata = current value, 0 cycles latency. Unmapped address -> rdata=0.
- Write value: RW: wdata. RS: old|wdata. RC: old&~wdata. Registered at the next posedge.
- Write suppression: RS/RC with wdata==0 performs no write and is never illegal on RO CSRs.
- Illegal: csr_valid && (unmapped, or counter address with HAS_COUNTERS=0, or write attempt to addr[11:10]==2'b11 or misa). When illegal, no state changes; the exception logic raises the trap.
- WARL: mepc[1:0] forced 0. mtvec[1:0] forced 0 (direct mode only).
- Trap entry (trap_valid):
  - mepc <= {trap_pc[XLEN-1:2],2'b00}, mcause <= trap_cause.
  - mstatus.MPIE(7) <= MIE(3), MIE <= 0, MPP(12:11) <= 2'b11.
  - redirect_pc = mtvec.
- mret (mret_valid): MIE <= MPIE, MPIE <= 1, MPP <= 2'b11. redirect_pc = mepc.
- Priority in a single cycle: trap > mret > CSR write. The losing events are dropped entirely.
- mcycle increments every non-reset cycle. minstret increments when instret_inc. Both are 64-bit with carry into the high half; they wrap at 2^64-1 -> 0.
- A CSR write to a counter half wins over that cycle's increment. The other half keeps its old value; no carry is applied that cycle.
- redirect_pc = 0 when neither trap_valid nor mret_valid.

Decomposition:
- Package csr_pkg: CSR address localparams, csr_op enum (NOP/RW/RS/RC), mstatus bit-position constants, misa constant.
- One sub-module, csr_counter64: 64-bit counter with inc, lo/hi write enables and data; instantiated twice.

Test Plan:
- Reset, then read 0x300 -> rdata 32'h1800, illegal=0. Read 0x305 -> 0.
- RW 0x305 wdata 32'h8000_0103 -> next-cycle read 32'h8000_0100. Then RS 0x340 with 0x0F over mscratch 0xF0 -> 0xFF. Then RC with 0x0F -> 0xF0.
- mstatus=0x1808, trap_valid with cause 0xB, pc 0x8000_0046 -> redirect_pc=mtvec same cycle. Next cycle: mepc=0x8000_0044, mcause=0xB, mstatus=0x1880.
- mret after the previous step -> redirect_pc=0x8000_0044. Next cycle mstatus=0x1888. Simultaneous trap+mret+RW mscratch -> only the trap takes effect.
- RW 0xB00 with 32'hFFFF_FFFF, mcycleh=0 -> following cycle reads mcycle=0, mcycleh=1. A write on the same cycle as an increment holds the written value exactly.
- RW to 0xF11 -> illegal=1, no state change. RS 0xF11 with wdata=0 -> illegal=0, rdata=0. HAS_COUNTERS=0: read 0xB00 -> illegal=1.
